// File: rtl/ka_seq_ctrl.sv
// Sequential Karatsuba controller: one W x W carry-less product through a shared
// external H x H carry-less core, using three time-multiplexed partial products.
module ka_seq_ctrl #(
    parameter int W       = 62,
    parameter int MUL_LAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-2:0]   y,
    output logic             busy,
    output logic             mul_en,
    output logic [W/2-1:0]   mul_a,
    output logic [W/2-1:0]   mul_b,
    input  logic [W-2:0]     mul_y
);

    localparam int H  = W / 2;
    localparam int PW = 2 * H - 1;
    localparam int YW = 2 * W - 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_reg, state_next;
    logic [1:0]    idx_reg, idx_next;
    logic [W-1:0]  a_reg, b_reg;
    logic [PW-1:0] p0_reg, p1_reg, p2_reg;
    logic [PW-1:0] p0_next, p1_next, p2_next, m_next;
    logic [YW-1:0] y_reg, y_next;
    logic          accept;
    logic          cap_valid;
    logic [1:0]    cap_tag;
    logic          final_cap;

    assign accept    = (state_reg == S_IDLE) && in_valid;
    assign final_cap = cap_valid && (cap_tag == 2'd2);

    assign in_ready  = (state_reg == S_IDLE);
    assign busy      = (state_reg != S_IDLE);
    assign out_valid = (state_reg == S_DONE);
    assign mul_en    = (state_reg == S_ISSUE);
    assign y         = y_reg;

    // Core operands: P0 from low halves, P2 from high halves, P1 from folded halves.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (state_reg == S_ISSUE) begin
            case (idx_reg)
                2'd0: begin
                    mul_a = a_reg[H-1:0];
                    mul_b = b_reg[H-1:0];
                end
                2'd1: begin
                    mul_a = a_reg[W-1:H];
                    mul_b = b_reg[W-1:H];
                end
                default: begin
                    mul_a = a_reg[H-1:0] ^ a_reg[W-1:H];
                    mul_b = b_reg[H-1:0] ^ b_reg[W-1:H];
                end
            endcase
        end
    end

    // The tag pipe tracks which partial product mul_y carries MUL_LAT cycles on.
    generate
        if (MUL_LAT == 0) begin : g_comb
            assign cap_valid = mul_en;
            assign cap_tag   = idx_reg;
        end else begin : g_pipe
            logic       pipe_v_reg   [MUL_LAT];
            logic [1:0] pipe_tag_reg [MUL_LAT];
            for (genvar gi = 0; gi < MUL_LAT; gi++) begin : g_stage
                if (gi == 0) begin : g_head
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            pipe_v_reg[0]   <= 1'b0;
                            pipe_tag_reg[0] <= 2'd0;
                        end else begin
                            pipe_v_reg[0]   <= mul_en;
                            pipe_tag_reg[0] <= idx_reg;
                        end
                    end
                end else begin : g_body
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            pipe_v_reg[gi]   <= 1'b0;
                            pipe_tag_reg[gi] <= 2'd0;
                        end else begin
                            pipe_v_reg[gi]   <= pipe_v_reg[gi-1];
                            pipe_tag_reg[gi] <= pipe_tag_reg[gi-1];
                        end
                    end
                end
            end
            assign cap_valid = pipe_v_reg[MUL_LAT-1];
            assign cap_tag   = pipe_tag_reg[MUL_LAT-1];
        end
    endgenerate

    // The result is built from the post-capture values so the final capture
    // and the result load can share one edge.
    always_comb begin
        p0_next = p0_reg;
        p1_next = p1_reg;
        p2_next = p2_reg;
        if (cap_valid) begin
            case (cap_tag)
                2'd0:    p0_next = mul_y;
                2'd1:    p2_next = mul_y;
                default: p1_next = mul_y;
            endcase
        end
        m_next = p0_next ^ p1_next ^ p2_next;
        y_next = YW'(p0_next) ^ (YW'(m_next) << H) ^ (YW'(p2_next) << W);
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_ISSUE;
                    idx_next   = 2'd0;
                end
            end
            S_ISSUE: begin
                if (idx_reg == 2'd2) begin
                    state_next = final_cap ? S_DONE : S_WAIT;
                    idx_next   = 2'd0;
                end else begin
                    idx_next = idx_reg + 2'd1;
                end
            end
            S_WAIT: begin
                if (final_cap) begin
                    state_next = S_DONE;
                end
            end
            default: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            idx_reg   <= 2'd0;
            a_reg     <= '0;
            b_reg     <= '0;
            p0_reg    <= '0;
            p1_reg    <= '0;
            p2_reg    <= '0;
            y_reg     <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            p0_reg    <= p0_next;
            p1_reg    <= p1_next;
            p2_reg    <= p2_next;
            if (accept) begin
                a_reg <= a;
                b_reg <= b;
            end
            if (final_cap) begin
                y_reg <= y_next;
            end
        end
    end

endmodule

// File: tb/tb_ka_seq_ctrl.sv
// Directed and random checks of ka_seq_ctrl against a plain carry-less multiply,
// with pipelined core models that drive garbage on mul_y when no product is due.
module tb_ka_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [127:0] garbage = '0;
    always @(negedge clk) garbage <= {$urandom(), $urandom(), $urandom(), $urandom()};

    function automatic logic [127:0] clmul(input logic [63:0] x, input logic [63:0] z);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (x[i]) r = r ^ ({64'b0, z} << i);
        end
        return r;
    endfunction

    // Small instances: W=6 with MUL_LAT 0 and 2.
    localparam int NS = 2;
    logic        s_iv [NS], s_ir [NS], s_ov [NS], s_or [NS], s_busy [NS], s_men [NS];
    logic [5:0]  s_a  [NS], s_b  [NS];
    logic [10:0] s_y  [NS];
    logic [2:0]  s_ma [NS], s_mb [NS];

    for (genvar gi = 0; gi < NS; gi++) begin : g_s
        localparam int LAT = (gi == 0) ? 0 : 2;
        logic [127:0] prod, pp;
        logic [127:0] pq [4];
        logic         pv [4];
        logic         vv;
        logic [4:0]   my;
        assign prod = clmul({61'b0, s_ma[gi]}, {61'b0, s_mb[gi]});
        always_ff @(posedge clk) begin
            pq[0] <= prod;
            pv[0] <= s_men[gi];
            for (int k = 1; k < 4; k++) begin
                pq[k] <= pq[k-1];
                pv[k] <= pv[k-1];
            end
        end
        always_comb begin
            vv = s_men[gi];
            pp = prod;
            if (LAT != 0) begin
                vv = pv[(LAT == 0) ? 0 : LAT-1];
                pp = pq[(LAT == 0) ? 0 : LAT-1];
            end
            my = vv ? pp[4:0] : garbage[4:0];
        end
        ka_seq_ctrl #(.W(6), .MUL_LAT(LAT)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(s_iv[gi]), .in_ready(s_ir[gi]),
            .a(s_a[gi]), .b(s_b[gi]),
            .out_valid(s_ov[gi]), .out_ready(s_or[gi]),
            .y(s_y[gi]), .busy(s_busy[gi]),
            .mul_en(s_men[gi]), .mul_a(s_ma[gi]), .mul_b(s_mb[gi]), .mul_y(my)
        );
    end

    // Full-width instances: W=62 with MUL_LAT 0, 1, 3.
    localparam int NB = 3;
    logic         b_iv [NB], b_ir [NB], b_ov [NB], b_or [NB], b_busy [NB], b_men [NB];
    logic [61:0]  b_a  [NB], b_b  [NB];
    logic [122:0] b_y  [NB];
    logic [30:0]  b_ma [NB], b_mb [NB];

    for (genvar gi = 0; gi < NB; gi++) begin : g_b
        localparam int LAT = (gi == 0) ? 0 : ((gi == 1) ? 1 : 3);
        logic [127:0] prod, pp;
        logic [127:0] pq [4];
        logic         pv [4];
        logic         vv;
        logic [60:0]  my;
        assign prod = clmul({33'b0, b_ma[gi]}, {33'b0, b_mb[gi]});
        always_ff @(posedge clk) begin
            pq[0] <= prod;
            pv[0] <= b_men[gi];
            for (int k = 1; k < 4; k++) begin
                pq[k] <= pq[k-1];
                pv[k] <= pv[k-1];
            end
        end
        always_comb begin
            vv = b_men[gi];
            pp = prod;
            if (LAT != 0) begin
                vv = pv[(LAT == 0) ? 0 : LAT-1];
                pp = pq[(LAT == 0) ? 0 : LAT-1];
            end
            my = vv ? pp[60:0] : garbage[60:0];
        end
        ka_seq_ctrl #(.W(62), .MUL_LAT(LAT)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(b_iv[gi]), .in_ready(b_ir[gi]),
            .a(b_a[gi]), .b(b_b[gi]),
            .out_valid(b_ov[gi]), .out_ready(b_or[gi]),
            .y(b_y[gi]), .busy(b_busy[gi]),
            .mul_en(b_men[gi]), .mul_a(b_ma[gi]), .mul_b(b_mb[gi]), .mul_y(my)
        );
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_random(input int i, input int n);
        bit got;
        for (int k = 0; k < n; k++) begin
            logic [61:0] ra, rb;
            logic [127:0] ref_y;
            ra = 62'({$urandom(), $urandom()});
            rb = 62'({$urandom(), $urandom()});
            ref_y = clmul({2'b0, ra}, {2'b0, rb});
            check("rnd_in_ready", b_ir[i], 1'b1);
            b_a[i]  = ra;
            b_b[i]  = rb;
            b_iv[i] = 1'b1;
            step();
            b_iv[i] = 1'b0;
            b_a[i]  = 62'({$urandom(), $urandom()});
            b_b[i]  = 62'({$urandom(), $urandom()});
            got = 1'b0;
            for (int t = 0; t < 40; t++) begin
                if (b_ov[i]) begin
                    if (!got) begin
                        check($sformatf("rnd_y[%0d]", i), b_y[i], ref_y);
                        got = 1'b1;
                    end
                    b_or[i] = 1'($urandom_range(0, 1));
                    if (b_or[i]) break;
                end
                step();
            end
            check("rnd_done", got, 1'b1);
            step();
            b_or[i] = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin
            s_iv[i] = 1'b0; s_or[i] = 1'b0; s_a[i] = '0; s_b[i] = '0;
        end
        for (int i = 0; i < NB; i++) begin
            b_iv[i] = 1'b0; b_or[i] = 1'b0; b_a[i] = '0; b_b[i] = '0;
        end

        #12;
        check("rst_in_ready", s_ir[0], 1'b1);
        check("rst_busy", s_busy[0], 1'b0);
        check("rst_out_valid", s_ov[0], 1'b0);
        check("rst_y", s_y[0], 11'h000);
        check("rst_mul_en", s_men[0], 1'b0);
        check("rst_mul_ab", {s_ma[0], s_mb[0]}, 6'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Directed product, MUL_LAT=0
        s_iv[0] = 1'b1; s_a[0] = 6'b101011; s_b[0] = 6'b110101;
        check("c0_in_ready", s_ir[0], 1'b1);
        step();
        s_iv[0] = 1'b0;
        check("c1_mul_en", s_men[0], 1'b1);
        check("c1_busy", s_busy[0], 1'b1);
        check("c1_in_ready", s_ir[0], 1'b0);
        check("c1_mul_ab", {s_ma[0], s_mb[0]}, {3'b011, 3'b101});
        step();
        check("c2_mul_ab", {s_ma[0], s_mb[0]}, {3'b101, 3'b110});
        step();
        check("c3_mul_ab", {s_ma[0], s_mb[0]}, {3'b110, 3'b011});
        step();
        check("c4_out_valid", s_ov[0], 1'b1);
        check("c4_y", s_y[0], 11'h757);
        check("c4_mul_en", s_men[0], 1'b0);
        check("c4_mul_ab", {s_ma[0], s_mb[0]}, 6'h00);

        // Backpressure with new operands waiting
        s_iv[0] = 1'b1; s_a[0] = 6'h3F; s_b[0] = 6'h3F;
        for (int c = 0; c < 10; c++) begin
            step();
            check("bp_y", s_y[0], 11'h757);
            check("bp_state", {s_ov[0], s_ir[0], s_busy[0], s_men[0]}, 4'b1010);
        end
        s_or[0] = 1'b1;
        check("hs_in_ready", s_ir[0], 1'b0);
        step();
        check("idle_flags", {s_ov[0], s_ir[0], s_busy[0]}, 3'b010);
        step();
        s_iv[0] = 1'b0; s_or[0] = 1'b0;
        check("ones_c1_mul_en", s_men[0], 1'b1);
        step(); step(); step();
        check("ones_out_valid", s_ov[0], 1'b1);
        check("ones_y", s_y[0], 11'h555);
        s_or[0] = 1'b1;
        step();
        s_or[0] = 1'b0; s_iv[0] = 1'b1; s_a[0] = 6'h00; s_b[0] = 6'h3F;
        check("zero_in_ready", s_ir[0], 1'b1);
        step();
        s_iv[0] = 1'b0;
        step(); step(); step();
        check("zero_out_valid", s_ov[0], 1'b1);
        check("zero_y", s_y[0], 11'h000);
        s_or[0] = 1'b1;
        step();
        s_or[0] = 1'b0;

        // Reset during the second issue cycle
        s_iv[0] = 1'b1; s_a[0] = 6'b101011; s_b[0] = 6'b110101;
        step();
        s_iv[0] = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        check("mrst_flags", {s_ir[0], s_busy[0], s_ov[0], s_men[0]}, 4'b1000);
        check("mrst_mul_ab", {s_ma[0], s_mb[0]}, 6'h00);
        check("mrst_y", s_y[0], 11'h000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            check("mrst_no_valid", {s_ov[0], s_busy[0]}, 2'b00);
        end
        s_iv[0] = 1'b1;
        step();
        s_iv[0] = 1'b0;
        step(); step(); step();
        check("post_rst_y", s_y[0], 11'h757);
        check("post_rst_ov", s_ov[0], 1'b1);
        s_or[0] = 1'b1;
        step();
        s_or[0] = 1'b0;

        // Same operands, MUL_LAT=2 with garbage on mul_y outside capture cycles
        s_iv[1] = 1'b1; s_a[1] = 6'b101011; s_b[1] = 6'b110101;
        check("l2_in_ready", s_ir[1], 1'b1);
        step();
        s_iv[1] = 1'b0;
        check("l2_c1_mul_en", s_men[1], 1'b1);
        step();
        check("l2_c2_mul_en", s_men[1], 1'b1);
        step();
        check("l2_c3_mul_en", s_men[1], 1'b1);
        step();
        check("l2_c4", {s_men[1], s_ov[1], s_busy[1]}, 3'b001);
        step();
        check("l2_c5", {s_men[1], s_ov[1], s_busy[1]}, 3'b001);
        step();
        check("l2_c6_out_valid", s_ov[1], 1'b1);
        check("l2_c6_y", s_y[1], 11'h757);
        for (int c = 0; c < 4; c++) begin
            step();
            check("l2_hold_y", s_y[1], 11'h757);
        end
        s_or[1] = 1'b1;
        step();
        s_or[1] = 1'b0;
        check("l2_idle", {s_ir[1], s_ov[1]}, 2'b10);

        // Random regression across core latencies
        for (int i = 0; i < NB; i++) begin
            run_random(i, 1000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ka_seq_ctrl.md
Name: ka_seq_ctrl

Overview:
- Sequential Karatsuba controller that computes one W x W carry-less (GF(2)[x]) product using a single shared H = W/2 bit carry-less multiplier core.
- The core sits outside this block; this block drives its operand ports and captures its results.
- The core is time-multiplexed over three partial products: low (P0), high (P2) and middle (P1). The controller applies the Karatsuba overlap-XOR recombination and returns a registered 2W-1 bit result over a valid/ready handshake.

Parameters:
W, 62, full operand width; must be even and >= 2; H = W/2.
MUL_LAT, 0, latency of the external core in cycles (0 = combinational: mul_y valid in the same cycle as its operands).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  controller can accept operands (high only in IDLE)
a  in  W  operand A, bit i = coefficient of x^i
b  in  W  operand B
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
y  out  2W-1  carry-less product a*b
busy  out  1  high in any state other than IDLE
mul_en  out  1  high in each cycle a new operand pair is presented to the core
mul_a  out  H  core operand A
mul_b  out  H  core operand B
mul_y  in  2H-1  core product, valid MUL_LAT cycles after the matching mul_en

Behaviour:
- Reset (asynchronous, rst_n low) takes effect immediately, including mid-operation:
  - state = IDLE, issue/capture counters = 0, delay pipe cleared, P0/P1/P2 registers = 0.
  - Outputs: y = 0, out_valid = 0, busy = 0, mul_en = 0, mul_a = 0, mul_b = 0, in_ready = 1.
  - Any in-flight operation is discarded. No result appears after reset release.
- States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch a and b, go to ISSUE. Call this acceptance cycle 0.
- ISSUE: lasts exactly 3 cycles (cycles 1, 2, 3), with mul_en = 1. mul_a/mul_b are combinational from the latched operands and the issue index:
  - idx0: a[H-1:0], b[H-1:0] (P0).
  - idx1: a[W-1:H], b[W-1:H] (P2).
  - idx2: a[H-1:0]^a[W-1:H], b[H-1:0]^b[W-1:H] (P1).
  - Outside ISSUE, mul_en = 0 and mul_a = mul_b = 0.
- Capture:
  - A MUL_LAT-deep shift pipe carries a valid bit and an index tag for each issue.
  - mul_y is captured into the P register named by the tag when that entry emerges, i.e. on cycle issue + MUL_LAT.
  - With MUL_LAT = 0, capture happens in the issue cycle itself.
- WAIT:
  - Entered after the third issue; holds until the idx2 capture.
  - If MUL_LAT = 0, WAIT is skipped: ISSUE goes directly to DONE.
- DONE entry (cycle 4+MUL_LAT):
  - y is registered as P0 ^ (M << H) ^ (P2 << W), where M = P0 ^ P1 ^ P2.
  - All terms are zero-extended to 2W-1 bits.
  - out_valid = 1 from this cycle.
- DONE hold:
  - y and out_valid stay stable until out_ready is high.
  - On out_valid & out_ready, out_valid drops next cycle and state returns to IDLE.
  - in_ready returns to 1 in that next cycle, not in the handshake cycle.
- in_valid outside IDLE is ignored. a and b are don't-care while in_ready = 0.
- mul_y is ignored unless a capture is due.
- Throughput: one product per 5+MUL_LAT cycles when out_ready is held high.
- busy = (state != IDLE).

Test Plan:
- Directed product, W=6, MUL_LAT=0:
  - Stimulus: a=6'b101011, b=6'b110101, core modelled as a carry-less multiplier.
  - mul_a sequence 011, 101, 110 and mul_b sequence 101, 110, 011 on cycles 1-3.
  - out_valid at cycle 4 with y=11'h757.
- Same operands, MUL_LAT=2 with a pipelined core model:
  - mul_en on cycles 1-3 only.
  - out_valid at cycle 6, y=11'h757.
  - Driving garbage on mul_y in non-capture cycles leaves y unchanged.
- All-ones operands, W=6: a=b=6'h3F -> y=11'h555. Also a=0, b=6'h3F -> y=0.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid, with in_valid=1 and new operands.
  - y stays 11'h757, in_ready=0, busy=1, no new issue.
  - Raise out_ready: IDLE next cycle, then the new operands are accepted.
- Reset mid-operation:
  - Assert rst_n=0 asynchronously during the second ISSUE cycle.
  - All outputs go to reset values immediately and no out_valid follows.
  - The next accepted operation gives the correct product.
- Random regression:
  - W=62 with MUL_LAT in {0,1,3}, 1000 back-to-back operations, random out_ready.
  - Every y matches the reference carry-less product.
